// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with stall/flush/bubble control, delay-slot flags and saturating perf counters
// Ports: clk, rst (async, active-high); stall[STALL_W] global stall vector; flush; in_valid/in_data/in_delay/next_delay upstream;
//        clr_cnt counter clear; out_valid/out_data/out_delay/is_delay registered outputs; stall_cnt/bubble_cnt/flush_cnt counters.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int STAGE = 2,
  parameter int STALL_W = 6,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_delay,
  input  logic               next_delay,
  input  logic               clr_cnt,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_delay,
  output logic               is_delay,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);
  // masks select the stall bits; for the last stage the downstream mask shifts out to zero
  localparam logic [STALL_W-1:0] UP_M = STALL_W'(1) << STAGE;
  localparam logic [STALL_W-1:0] DN_M = STALL_W'(1) << (STAGE + 1);
  logic up, dn, bubble, kill;
  assign up = |(stall & UP_M);
  assign dn = |(stall & DN_M);
  assign bubble = ~flush & up & ~dn;
  assign kill = flush | bubble;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= NOP_VAL;
      out_valid <= 1'b0;
      out_delay <= 1'b0;
      is_delay  <= 1'b0;
    end else if (kill) begin
      out_data  <= NOP_VAL;
      out_valid <= 1'b0;
      out_delay <= 1'b0;
      is_delay  <= 1'b0;
    end else if (!up) begin
      out_data  <= in_data;
      out_valid <= in_valid;
      out_delay <= in_delay;
      is_delay  <= next_delay;
    end
  end
  // increments are gated by all-ones so counters saturate instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      stall_cnt  <= clr_cnt ? '0 : stall_cnt + CNT_W'(up & ~flush & ~&stall_cnt);
      bubble_cnt <= clr_cnt ? '0 : bubble_cnt + CNT_W'(bubble & ~&bubble_cnt);
      flush_cnt  <= clr_cnt ? '0 : flush_cnt + CNT_W'(flush & ~&flush_cnt);
    end
  end
endmodule
